// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: shares one synchronous-read, byte-write RAM port between
// instruction fetch (IF, read-only) and the memory stage (MEM, load/store).
//
// MEM has fixed priority. After StarveLimit consecutive denied IF cycles,
// IF wins the next contention. Read data returns one cycle after the grant,
// steered to whichever requester owns the read.
//
// Ports:
//   clk_i, rst_ni                      clock, async active-low reset
//   if_req_i/if_addr_i                 IF read request and word address
//   if_gnt_o/if_rvalid_o/if_rdata_o    IF grant and read response
//   mem_req_i/mem_wen_i/mem_addr_i/
//   mem_wdata_i                        MEM request (wen == 0 means load)
//   mem_gnt_o/mem_rvalid_o/mem_rdata_o MEM grant and load response
//   ram_en_o/ram_wen_o/ram_addr_o/
//   ram_wdata_o/ram_rdata_i            shared RAM port
//   conflict_cnt_o                     cycles with both requests high
module dm_port_arbiter #(
  parameter int unsigned StarveLimit = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        mem_req_i,
  input  logic [3:0]  mem_wen_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic        mem_gnt_o,
  output logic        mem_rvalid_o,
  output logic [31:0] mem_rdata_o,
  output logic        ram_en_o,
  output logic [3:0]  ram_wen_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  input  logic [31:0] ram_rdata_i,
  output logic [31:0] conflict_cnt_o
);

  localparam logic [3:0] Limit = 4'(StarveLimit);

  typedef enum logic [1:0] {OwnNone, OwnIf, OwnMem} owner_e;

  owner_e      rd_owner_q, rd_owner_d;
  logic [3:0]  starve_q, starve_d;
  logic [31:0] conflict_q, conflict_d;
  logic        starve_hit;
  logic        if_gnt, mem_gnt;

  assign starve_hit = (starve_q == Limit);

  // Grants are gated by reset so nothing reaches the RAM while held in reset.
  always_comb begin
    if_gnt  = rst_ni & if_req_i & (~mem_req_i | starve_hit);
    mem_gnt = rst_ni & mem_req_i & ~if_gnt;
  end

  always_comb begin
    starve_d = starve_q;
    if (!if_req_i || if_gnt) begin
      starve_d = 4'd0;
    end else if (starve_q < Limit) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_comb begin
    rd_owner_d = OwnNone;
    if (if_gnt) begin
      rd_owner_d = OwnIf;
    end else if (mem_gnt && (mem_wen_i == 4'b0000)) begin
      rd_owner_d = OwnMem;
    end
  end

  assign conflict_d = (if_req_i && mem_req_i) ? conflict_q + 32'd1 : conflict_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_owner_q <= OwnNone;
      starve_q   <= 4'd0;
      conflict_q <= 32'd0;
    end else begin
      rd_owner_q <= rd_owner_d;
      starve_q   <= starve_d;
      conflict_q <= conflict_d;
    end
  end

  always_comb begin
    ram_en_o    = if_gnt | mem_gnt;
    ram_addr_o  = 32'd0;
    ram_wen_o   = 4'b0000;
    ram_wdata_o = 32'd0;
    if (if_gnt) begin
      ram_addr_o = if_addr_i;
    end else if (mem_gnt) begin
      ram_addr_o  = mem_addr_i;
      ram_wen_o   = mem_wen_i;
      ram_wdata_o = mem_wdata_i;
    end
  end

  assign if_gnt_o       = if_gnt;
  assign mem_gnt_o      = mem_gnt;
  assign if_rvalid_o    = (rd_owner_q == OwnIf);
  assign mem_rvalid_o   = (rd_owner_q == OwnMem);
  assign if_rdata_o     = if_rvalid_o ? ram_rdata_i : 32'd0;
  assign mem_rdata_o    = mem_rvalid_o ? ram_rdata_i : 32'd0;
  assign conflict_cnt_o = conflict_q;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Self-checking bench for dm_port_arbiter: directed scenarios plus random
// traffic, all compared against a behavioural model of arbitration, RAM
// contents and read responses.
module tb_dm_port_arbiter;

  localparam int unsigned Lim = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, mem_req;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [3:0]  mem_wen;
  logic        if_gnt, if_rvalid, mem_gnt, mem_rvalid, ram_en;
  logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata, ram_rdata, conflict_cnt;
  logic [3:0]  ram_wen;

  int errors = 0;
  int checks = 0;

  dm_port_arbiter #(.StarveLimit(Lim)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .mem_req_i(mem_req), .mem_wen_i(mem_wen), .mem_addr_i(mem_addr),
    .mem_wdata_i(mem_wdata), .mem_gnt_o(mem_gnt), .mem_rvalid_o(mem_rvalid),
    .mem_rdata_o(mem_rdata), .ram_en_o(ram_en), .ram_wen_o(ram_wen),
    .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata),
    .conflict_cnt_o(conflict_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural RAM attached to the DUT port.
  logic [31:0] ram_mem [logic [31:0]];
  always @(posedge clk) begin
    if (ram_en) begin
      logic [31:0] w;
      w = ram_mem.exists(ram_addr) ? ram_mem[ram_addr] : 32'd0;
      if (ram_wen == 4'b0000) begin
        ram_rdata <= w;
      end else begin
        for (int b = 0; b < 4; b++) if (ram_wen[b]) w[8*b +: 8] = ram_wdata[8*b +: 8];
        ram_mem[ram_addr] = w;
      end
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [logic [31:0]];
  int unsigned waited;      // cycles the current IF request has been refused
  logic [31:0] conflicts;
  int          pend_kind;   // 0 none, 1 IF read, 2 MEM load
  logic [31:0] pend_data;
  logic        e_if_gnt, e_mem_gnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'd0;
  endfunction

  // One clock cycle: inputs already driven; check, advance edge, update model.
  task automatic step();
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_wen;
    #1;
    if (!rst_n) begin
      waited = 0; conflicts = 32'd0; pend_kind = 0;
    end
    e_if_gnt  = rst_n && if_req && (!mem_req || waited >= Lim);
    e_mem_gnt = rst_n && mem_req && !e_if_gnt;
    e_addr  = e_if_gnt ? if_addr : (e_mem_gnt ? mem_addr : 32'd0);
    e_wen   = e_mem_gnt ? mem_wen : 4'd0;
    e_wdata = e_mem_gnt ? mem_wdata : 32'd0;
    check_eq("if_gnt", 32'(if_gnt), 32'(e_if_gnt));
    check_eq("mem_gnt", 32'(mem_gnt), 32'(e_mem_gnt));
    check_eq("ram_en", 32'(ram_en), 32'(e_if_gnt | e_mem_gnt));
    check_eq("ram_addr", ram_addr, e_addr);
    check_eq("ram_wen", 32'(ram_wen), 32'(e_wen));
    check_eq("ram_wdata", ram_wdata, e_wdata);
    check_eq("if_rvalid", 32'(if_rvalid), 32'(pend_kind == 1));
    check_eq("mem_rvalid", 32'(mem_rvalid), 32'(pend_kind == 2));
    check_eq("if_rdata", if_rdata, (pend_kind == 1) ? pend_data : 32'd0);
    check_eq("mem_rdata", mem_rdata, (pend_kind == 2) ? pend_data : 32'd0);
    check_eq("conflict_cnt", conflict_cnt, conflicts);
    @(posedge clk);
    if (rst_n) begin
      pend_kind = 0;
      if (e_if_gnt) begin
        pend_kind = 1; pend_data = ref_rd(if_addr);
      end else if (e_mem_gnt && mem_wen == 4'd0) begin
        pend_kind = 2; pend_data = ref_rd(mem_addr);
      end else if (e_mem_gnt) begin
        logic [31:0] w;
        w = ref_rd(mem_addr);
        for (int b = 0; b < 4; b++) if (mem_wen[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
        ref_mem[mem_addr] = w;
      end
      if (if_req && mem_req) conflicts = conflicts + 32'd1;
      if (if_req && !e_if_gnt) waited = (waited < Lim) ? waited + 1 : waited;
      else waited = 0;
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_addr();
    return 32'h100 + {$urandom_range(0, 7), 2'b00};
  endfunction

  initial begin
    waited = 0; conflicts = 32'd0; pend_kind = 0; pend_data = 32'd0;
    e_if_gnt = 1'b0; e_mem_gnt = 1'b0;
    ram_rdata = 32'd0;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a, v;
      a = 32'h100 + 32'(i * 4);
      v = $urandom;
      ram_mem[a] = v; ref_mem[a] = v;
    end
    ram_mem[32'h100] = 32'hDEADBEEF; ref_mem[32'h100] = 32'hDEADBEEF;
    ram_mem[32'h200] = 32'hAABBCCDD; ref_mem[32'h200] = 32'hAABBCCDD;

    // Reset with both requests held: everything quiet.
    rst_n = 1'b0; if_req = 1'b1; mem_req = 1'b1;
    if_addr = 32'h104; mem_addr = 32'h108; mem_wen = 4'd0; mem_wdata = 32'd0;
    @(negedge clk);
    step(); step();
    rst_n = 1'b1;
    step();
    check_eq("rst_conf_one_edge", conflict_cnt, 32'd1);
    if_req = 1'b0; mem_req = 1'b0;
    step();

    // IF only read of 0x100.
    if_req = 1'b1; if_addr = 32'h100;
    step();
    if_req = 1'b0;
    check_eq("if_only_rvalid", 32'(if_rvalid), 32'd1);
    check_eq("if_only_data", if_rdata, 32'hDEADBEEF);
    check_eq("if_only_mem_rvalid", 32'(mem_rvalid), 32'd0);
    step();

    // Half-word store then load back.
    mem_req = 1'b1; mem_addr = 32'h200; mem_wen = 4'b0011; mem_wdata = 32'h11223344;
    step();
    mem_req = 1'b0; mem_wen = 4'd0;
    check_eq("store_no_rvalid", 32'(mem_rvalid | if_rvalid), 32'd0);
    step();
    mem_req = 1'b1;
    step();
    mem_req = 1'b0;
    check_eq("load_after_store", mem_rdata, 32'hAABB3344);
    step();

    // Continuous contention: IF every fifth cycle.
    if_req = 1'b1; if_addr = 32'h10c; mem_req = 1'b1; mem_addr = 32'h110;
    for (int i = 0; i < 15; i++) begin
      #1;
      check_eq("starve_pattern", 32'(if_gnt), 32'((i % 5) == 4));
      step();
    end
    if_req = 1'b0; mem_req = 1'b0;
    step();

    // MEM load then IF read in adjacent cycles.
    mem_req = 1'b1; mem_addr = 32'h114;
    step();
    mem_req = 1'b0; if_req = 1'b1; if_addr = 32'h118;
    check_eq("b2b_mem_data", mem_rdata, ref_rd(32'h114));
    step();
    if_req = 1'b0;
    check_eq("b2b_if_data", if_rdata, ref_rd(32'h118));
    check_eq("b2b_no_overlap", 32'(mem_rvalid), 32'd0);
    step();

    // Reset in the cycle after an IF grant discards the read.
    if_req = 1'b1; if_addr = 32'h100;
    step();
    if_req = 1'b0; rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check_eq("rst_discard_rvalid", 32'(if_rvalid), 32'd0);

    // Random traffic obeying the hold-until-grant protocol.
    for (int c = 0; c < 400; c++) begin
      step();
      if (!if_req || e_if_gnt) begin
        if_req = 1'($urandom_range(0, 1)); if_addr = rand_addr();
      end
      if (!mem_req || e_mem_gnt) begin
        mem_req = 1'($urandom_range(0, 1)); mem_addr = rand_addr();
        mem_wen = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'd0;
        mem_wdata = $urandom;
      end
    end
    if_req = 1'b0; mem_req = 1'b0;
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dm_port_arbiter.md
# dm_port_arbiter

Shares one synchronous-read, byte-write data RAM port between the instruction-fetch requester (IF, read-only) and the memory stage (MEM, load/store) of the five-stage pipeline. MEM has fixed priority, with an anti-starvation guard that forces one IF grant after a bounded wait. Read data returns one cycle after grant, tagged to the owning requester. A free-running conflict counter feeds the performance display.

## Interface
- STARVE_LIMIT, 4: consecutive denied IF-request cycles after which IF wins the next contention (1..15).
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- if_req  in  1  IF read request; addr held stable until if_gnt
- if_addr  in  32  IF word address
- if_gnt  out  1  IF request accepted this cycle
- if_rvalid  out  1  if_rdata valid this cycle
- if_rdata  out  32  read data for IF
- mem_req  in  1  MEM request; inputs held stable until mem_gnt
- mem_wen  in  4  byte write enables; 4'b0000 = load
- mem_addr  in  32  MEM address
- mem_wdata  in  32  MEM store data, already byte-lane aligned
- mem_gnt  out  1  MEM request accepted this cycle
- mem_rvalid  out  1  mem_rdata valid this cycle (loads only)
- mem_rdata  out  32  read data for MEM
- ram_en  out  1  RAM port enable
- ram_wen  out  4  RAM byte write enables
- ram_addr  out  32  RAM address
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data, valid one cycle after a read enable
- conflict_cnt  out  32  count of cycles with if_req && mem_req

## Operation
- Grant is combinational from this cycle's requests and registered state; at most one grant per cycle.
- Arbitration: only one requester -> it is granted. Both -> MEM granted unless starve_cnt == STARVE_LIMIT, then IF granted.
- starve_cnt (4-bit register): +1 on each cycle with if_req && !if_gnt, saturating at STARVE_LIMIT; cleared on if_gnt or !if_req.
- RAM drive: ram_en = if_gnt | mem_gnt. Selected requester's address drives ram_addr. ram_wen = mem_wen when mem_gnt, else 0. ram_wdata = mem_wdata when mem_gnt, else 0. When idle, ram_addr and ram_wdata are 0.
- Read tag register rd_owner ∈ {NONE, IF, MEM}, loaded every cycle:
  - IF on if_gnt
  - MEM on mem_gnt with mem_wen == 0
  - NONE otherwise (stores included)
- Response: if_rvalid = (rd_owner == IF); mem_rvalid = (rd_owner == MEM). Both rdata outputs are ram_rdata gated to 0 when their rvalid is low.
- Pipelined: a new grant may issue in the same cycle as the previous read's rvalid. Throughput is one access per cycle.
- conflict_cnt: +1 each cycle both requests are high; wraps 0xFFFF_FFFF -> 0.
- Reset (asynchronous, any time): rd_owner = NONE, starve_cnt = 0, conflict_cnt = 0. A read in flight is discarded: no rvalid after reset release.
- Reset values of outputs, with inputs low: all gnt/rvalid/rdata/ram_* = 0, conflict_cnt = 0.

## Timing
- Cycle N: req high and granted -> ram_en high in N.
  - Read: rvalid and rdata in N+1.
  - Store: complete in N; no response.
- The requester must keep req/addr/wdata stable until it sees gnt, and may drop req or present the next request in N+1.
- Worst-case IF wait under continuous MEM traffic is STARVE_LIMIT cycles. IF is granted in the (STARVE_LIMIT+1)-th requesting cycle.
- Only the MEM-issued grants are held off by IF. A MEM request that loses is granted no later than the next cycle (starve_cnt clears on if_gnt).

## Test plan
- Reset with if_req=mem_req=1 held: all outputs 0. After resetn rises: mem_gnt=1 in the first cycle. conflict_cnt=1 after one edge.
- IF only, addr 0x100, RAM word 0xDEADBEEF: if_gnt in N, ram_addr=0x100, if_rvalid=1 and if_rdata=0xDEADBEEF in N+1, mem_rvalid=0.
- MEM store 0x11223344, wen=4'b0011 at 0x200: mem_gnt, ram_wen=0011 in N. No rvalid in N+1. A following load of 0x200 returns the updated lower half.
- Both requests held continuously, STARVE_LIMIT=4: MEM granted 4 cycles, IF granted in the 5th, then MEM again. The pattern repeats every 5 cycles and conflict_cnt advances by 1 per cycle.
- Back-to-back MEM load then IF read in adjacent cycles: mem_rvalid in N+1 and if_rvalid in N+2, each with the correct word and no overlap.
- resetn pulsed low in the cycle after an IF read grant: if_rvalid stays 0 and no stale data appears after release.
